// File: rtl/operand_fetch_if.sv
// Handshake and data bundle around the RiSC-16 operand-fetch stage:
// fetch-side instruction port, writeback port and the execute-side pipeline slot.
interface operand_fetch_if #(
  parameter int XLEN = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;

  logic            wb_en;
  logic [2:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      alu_op;
  logic [2:0]      out_opcode;
  logic [2:0]      out_rd;
  logic [XLEN-1:0] out_store;

  // Environment side: drives instructions, writebacks and downstream ready.
  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, op1, op2, alu_op, out_opcode, out_rd, out_store
  );

  // Stage side.
  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, op1, op2, alu_op, out_opcode, out_rd, out_store
  );
endinterface

// File: rtl/operand_fetch.sv
// RiSC-16 decode/operand-fetch stage: 8x16 register file with write-to-read
// bypass, instruction decode and a single registered valid/ready output slot.
module operand_fetch #(
  parameter int XLEN  = 16,
  parameter int NREGS = 8
) (
  input logic           clk,
  input logic           rst_n,
  operand_fetch_if.slave bus
);

  logic [XLEN-1:0] rf [NREGS];

  logic [2:0]      opcode, ra, rb, rc;
  logic [6:0]      imm7;
  logic [9:0]      imm10;
  logic [XLEN-1:0] ra_val, rb_val, rc_val, sext7, lui_imm;
  logic [XLEN-1:0] nxt_op1, nxt_op2;
  logic [2:0]      nxt_alu, nxt_rd;
  logic            capture;

  assign opcode  = bus.in_instr[15:13];
  assign ra      = bus.in_instr[12:10];
  assign rb      = bus.in_instr[9:7];
  assign rc      = bus.in_instr[2:0];
  assign imm7    = bus.in_instr[6:0];
  assign imm10   = bus.in_instr[9:0];
  assign sext7   = {{(XLEN-7){imm7[6]}}, imm7};
  assign lui_imm = {imm10, 6'b0};

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  // A writeback landing in the capture cycle wins over the stale array value.
  function automatic logic [XLEN-1:0] read_reg(input logic [2:0] a);
    if (a == 3'd0)
      return '0;
    else if (bus.wb_en && bus.wb_addr == a)
      return bus.wb_data;
    else
      return rf[a];
  endfunction

  always_comb begin
    ra_val = read_reg(ra);
    rb_val = read_reg(rb);
    rc_val = read_reg(rc);
  end

  always_comb begin
    nxt_op1 = '0;
    nxt_op2 = '0;
    nxt_alu = 3'b000;
    nxt_rd  = ra;
    case (opcode)
      3'b000: begin nxt_op1 = rb_val; nxt_op2 = rc_val; end
      3'b001: begin nxt_op1 = rb_val; nxt_op2 = sext7; end
      3'b010: begin nxt_op1 = rb_val; nxt_op2 = rc_val; nxt_alu = 3'b001; end
      3'b011: begin nxt_op2 = lui_imm; end
      3'b100: begin nxt_op1 = rb_val; nxt_op2 = sext7; nxt_rd = 3'd0; end
      3'b101: begin nxt_op1 = rb_val; nxt_op2 = sext7; end
      3'b110: begin nxt_op1 = ra_val; nxt_op2 = rb_val; nxt_rd = 3'd0; end
      default: begin nxt_op1 = rb_val; end
    endcase
  end

  // rf[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      bus.out_valid  <= 1'b0;
      bus.op1        <= '0;
      bus.op2        <= '0;
      bus.alu_op     <= 3'b000;
      bus.out_opcode <= 3'b000;
      bus.out_rd     <= 3'b000;
      bus.out_store  <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 3'd0)
        rf[bus.wb_addr] <= bus.wb_data;
      if (capture) begin
        bus.out_valid  <= 1'b1;
        bus.op1        <= nxt_op1;
        bus.op2        <= nxt_op2;
        bus.alu_op     <= nxt_alu;
        bus.out_opcode <= opcode;
        bus.out_rd     <= nxt_rd;
        bus.out_store  <= ra_val;
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: decode of every opcode, r0 handling,
// writeback bypass, backpressure and reset of a stalled slot.
module tb_operand_fetch;

  logic clk;
  logic rst_n;
  int   cmp_cnt;
  int   fail_cnt;

  operand_fetch_if #(.XLEN(16)) bus ();

  operand_fetch #(.XLEN(16), .NREGS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_rrr(input logic [2:0] op, input logic [2:0] ra,
                                          input logic [2:0] rb, input logic [2:0] rc);
    return {op, ra, rb, 4'b0000, rc};
  endfunction

  function automatic logic [15:0] enc_ri(input logic [2:0] op, input logic [2:0] ra,
                                         input logic [2:0] rb, input logic [6:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [15:0] o1,
                            input logic [15:0] o2, input logic [2:0] alu, input logic [2:0] opc,
                            input logic [2:0] rd, input logic [15:0] st);
    check_output({tag, ".valid"}, {15'b0, bus.out_valid}, {15'b0, v});
    check_output({tag, ".op1"}, bus.op1, o1);
    check_output({tag, ".op2"}, bus.op2, o2);
    check_output({tag, ".alu"}, {13'b0, bus.alu_op}, {13'b0, alu});
    check_output({tag, ".opc"}, {13'b0, bus.out_opcode}, {13'b0, opc});
    check_output({tag, ".rd"}, {13'b0, bus.out_rd}, {13'b0, rd});
    check_output({tag, ".store"}, bus.out_store, st);
  endtask

  task automatic apply_stimulus(input logic iv, input logic [15:0] instr, input logic ordy,
                                input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bus.in_valid  = iv;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_cnt  = 0;
    fail_cnt = 0;
    rst_n    = 1'b0;
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    step();
    check_slot("reset", 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    rst_n = 1'b1;
    step();
    check_output("ready_after_reset", {15'b0, bus.in_ready}, 16'h0001);

    // Preload r1=5, r2=7 through the writeback port.
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 3'd1, 16'h0005);
    step();
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 3'd2, 16'h0007);
    step();

    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd3, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("add", 1'b1, 16'h0005, 16'h0007, 3'd0, 3'd0, 3'd3, 16'h0000);

    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 3'd1, 16'h00FF);
    step();
    check_output("drain_valid", {15'b0, bus.out_valid}, 16'h0000);

    apply_stimulus(1'b1, enc_rrr(3'b010, 3'd1, 3'd1, 3'd1), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("nand", 1'b1, 16'h00FF, 16'h00FF, 3'd1, 3'd2, 3'd1, 16'h00FF);

    apply_stimulus(1'b1, enc_ri(3'b001, 3'd2, 3'd0, 7'h7F), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("addi", 1'b1, 16'h0000, 16'hFFFF, 3'd0, 3'd1, 3'd2, 16'h0007);

    apply_stimulus(1'b1, {3'b011, 3'd4, 10'h3FF}, 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("lui", 1'b1, 16'h0000, 16'hFFC0, 3'd0, 3'd3, 3'd4, 16'h0000);

    // A write to r0 must neither bypass nor stick.
    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd7, 3'd0, 3'd0), 1'b1, 1'b1, 3'd0, 16'hBEEF);
    step();
    check_slot("r0_bypass", 1'b1, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h0000);

    apply_stimulus(1'b1, enc_ri(3'b110, 3'd0, 3'd1, 7'h05), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("beq_r0", 1'b1, 16'h0000, 16'h00FF, 3'd0, 3'd6, 3'd0, 16'h0000);

    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd5, 3'd6, 3'd6), 1'b1, 1'b1, 3'd6, 16'h1234);
    step();
    check_slot("bypass", 1'b1, 16'h1234, 16'h1234, 3'd0, 3'd0, 3'd5, 16'h0000);

    apply_stimulus(1'b1, enc_ri(3'b111, 3'd1, 3'd6, 7'h00), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("jalr", 1'b1, 16'h1234, 16'h0000, 3'd0, 3'd7, 3'd1, 16'h00FF);

    apply_stimulus(1'b1, enc_ri(3'b100, 3'd6, 3'd2, 7'h7E), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("sw", 1'b1, 16'h0007, 16'hFFFE, 3'd0, 3'd4, 3'd0, 16'h1234);

    apply_stimulus(1'b1, enc_ri(3'b101, 3'd3, 3'd1, 7'h05), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("lw", 1'b1, 16'h00FF, 16'h0005, 3'd0, 3'd5, 3'd3, 16'h0000);

    // Stall with a new instruction waiting; r1 is rewritten mid-stall.
    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd3, 3'd1, 3'd2), 1'b0, 1'b1, 3'd1, 16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wb_en = 1'b0;
      check_slot("stall", 1'b1, 16'h00FF, 16'h0005, 3'd0, 3'd5, 3'd3, 16'h0000);
      check_output("stall_ready", {15'b0, bus.in_ready}, 16'h0000);
    end
    bus.out_ready = 1'b1;
    step();
    check_slot("release", 1'b1, 16'hAAAA, 16'h0007, 3'd0, 3'd0, 3'd3, 16'h0000);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_output("no_dup", {15'b0, bus.out_valid}, 16'h0000);

    // Reset on top of a stalled slot, with a writeback that must be ignored.
    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0, 3'd0, 16'h0);
    step();
    check_output("pre_reset_valid", {15'b0, bus.out_valid}, 16'h0001);
    rst_n = 1'b0;
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 3'd2, 16'h5555);
    step();
    check_slot("stall_reset", 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 16'h0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_output("ready_after_reset2", {15'b0, bus.in_ready}, 16'h0001);
    apply_stimulus(1'b1, enc_rrr(3'b000, 3'd3, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, 16'h0);
    step();
    check_slot("cleared_regs", 1'b1, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd3, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
